// File: rtl/corescore_axis_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-stream byte sink among NUM_SOURCES sources.
// A grant is held from the first beat to the tlast beat; an optional watchdog force-ends runaway packets.
module corescore_axis_rr_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BEATS   = 256
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_tdata,
    input  logic [NUM_SOURCES-1:0]            i_tlast,
    input  logic [NUM_SOURCES-1:0]            i_tvalid,
    output logic [NUM_SOURCES-1:0]            o_tready,
    output logic [DATA_WIDTH-1:0]             o_tdata,
    output logic                              o_tlast,
    output logic                              o_tvalid,
    input  logic                              i_tready,
    output logic [NUM_SOURCES-1:0]            o_grant,
    output logic                              o_trunc
);

    localparam int PTR_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int CNT_W_RAW = $clog2(MAX_BEATS + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam bit WD_EN     = (MAX_BEATS > 0);
    localparam int WD_LAST_I = (MAX_BEATS > 0) ? (MAX_BEATS - 1) : 0;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_LAST_I);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [NUM_SOURCES-1:0] grant;
    logic [PTR_W-1:0]       gidx;
    logic [PTR_W-1:0]       ptr;
    logic [CNT_W-1:0]       beats;

    logic                   sel_found;
    logic [PTR_W-1:0]       sel_idx;
    logic [PTR_W-1:0]       cand;

    logic [DATA_WIDTH-1:0]  src_data;
    logic                   src_valid;
    logic                   src_last;
    logic                   locked;
    logic                   wd_hit;
    logic                   beat;

    // Explicit wrap keeps non-power-of-2 source counts inside the legal index range.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
        if (idx == PTR_W'(NUM_SOURCES - 1)) begin
            return '0;
        end
        return idx + PTR_W'(1);
    endfunction

    // Rotating priority scan starting at ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!sel_found && i_tvalid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        src_data  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (gidx == PTR_W'(k)) begin
                src_data  = i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                src_valid = i_tvalid[k];
                src_last  = i_tlast[k];
            end
        end
    end

    assign locked   = (state == LOCKED);
    assign wd_hit   = WD_EN && (beats == WD_LAST);
    assign o_tvalid = locked && src_valid;
    assign o_tdata  = locked ? src_data : '0;
    assign o_tlast  = locked && (src_last || wd_hit);
    assign o_tready = (locked && i_tready) ? grant : '0;
    assign o_grant  = grant;
    assign beat     = o_tvalid && i_tready;
    // A forced release is one where the watchdog, not the source, ended the packet.
    assign o_trunc  = beat && wd_hit && !src_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            ptr   <= '0;
            beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state <= LOCKED;
                        grant <= NUM_SOURCES'(1) << sel_idx;
                        gidx  <= sel_idx;
                        beats <= '0;
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        if (o_tlast) begin
                            state <= IDLE;
                            grant <= '0;
                            beats <= '0;
                            ptr   <= wrap_inc(gidx);
                        end else if (WD_EN) begin
                            beats <= beats + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corescore_axis_rr_arbiter.sv
// Bench for corescore_axis_rr_arbiter: vector table, directed corner sequences and a
// randomized run against a packet-level reference model (4-source watchdog and 3-source no-watchdog instances).
module tb_corescore_axis_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]  tv4, tl4, otr4, og4;
    logic [31:0] td4;
    logic        tr4, ol4, ov4, ot4;
    logic [7:0]  od4;

    logic [2:0]  tv3, tl3, otr3, og3;
    logic [23:0] td3;
    logic        tr3, ol3, ov3, ot3;
    logic [7:0]  od3;

    corescore_axis_rr_arbiter #(.NUM_SOURCES(4), .DATA_WIDTH(8), .MAX_BEATS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_tdata(td4), .i_tlast(tl4), .i_tvalid(tv4),
        .o_tready(otr4), .o_tdata(od4), .o_tlast(ol4), .o_tvalid(ov4), .i_tready(tr4),
        .o_grant(og4), .o_trunc(ot4)
    );

    corescore_axis_rr_arbiter #(.NUM_SOURCES(3), .DATA_WIDTH(8), .MAX_BEATS(0)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_tdata(td3), .i_tlast(tl3), .i_tvalid(tv3),
        .o_tready(otr3), .o_tdata(od3), .o_tlast(ol3), .o_tvalid(ov3), .i_tready(tr3),
        .o_grant(og3), .o_trunc(ot3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        tr;
        logic [3:0]  eg;
        logic [3:0]  etr;
        logic        ev;
        logic        el;
        logic        et;
        logic [7:0]  ed;
    } vec_t;

    typedef struct {
        int owner;   // -1 when no packet is in progress
        int beats;
        int ptr;
    } mstate_t;

    function automatic vec_t mkv(input logic r, input logic [3:0] tv, input logic [3:0] tl,
                                 input logic [31:0] td, input logic tr, input logic [3:0] eg,
                                 input logic [3:0] etr, input logic ev, input logic el,
                                 input logic et, input logic [7:0] ed);
        vec_t v;
        v.rst = r;  v.tv = tv;   v.tl = tl; v.td = td; v.tr = tr;
        v.eg  = eg; v.etr = etr; v.ev = ev; v.el = el; v.et = et; v.ed = ed;
        return v;
    endfunction

    // Data only matters when valid is expected; otherwise it is masked to zero.
    function automatic logic [63:0] pk(input logic [3:0] g, input logic [3:0] tr, input logic v,
                                       input logic l, input logic t, input logic [7:0] d);
        return {45'h0, g, tr, v, l, t, (v ? d : 8'h00)};
    endfunction

    function automatic logic [63:0] act4();
        return pk(og4, otr4, ov4, ol4, ot4, od4);
    endfunction

    function automatic logic [63:0] act3();
        return pk({1'b0, og3}, {1'b0, otr3}, ov3, ol3, ot3, od3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tv4 = '0; tl4 = '0; td4 = '0; tr4 = 1'b0;
        tv3 = '0; tl3 = '0; td3 = '0; tr3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: outputs from the current packet owner, then the next state by the arbitration rules.
    task automatic model_cycle(input int n, input int maxb, input logic r, input logic [3:0] tv,
                               input logic [3:0] tl, input logic [31:0] td, input logic tr,
                               inout mstate_t m, output logic [63:0] exp);
        logic [3:0] oh;
        logic       v, l, lim;
        bit         found;
        if (m.owner < 0) begin
            exp = pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00);
            v = 1'b0; l = 1'b0;
        end else begin
            oh  = 4'(1 << m.owner);
            lim = (maxb > 0) && (m.beats == maxb - 1);
            v   = tv[m.owner];
            l   = tl[m.owner] || lim;
            exp = pk(oh, tr ? oh : 4'h0, v, l, v && tr && lim && !tl[m.owner], td[m.owner*8 +: 8]);
        end
        if (r) begin
            m.owner = -1; m.beats = 0; m.ptr = 0;
        end else if (m.owner < 0) begin
            found = 0;
            for (int i = 0; i < n; i++) begin
                if (!found && tv[(m.ptr + i) % n]) begin
                    found   = 1;
                    m.owner = (m.ptr + i) % n;
                    m.beats = 0;
                end
            end
        end else if (v && tr) begin
            if (l) begin
                m.ptr   = (m.owner + 1) % n;
                m.owner = -1;
                m.beats = 0;
            end else begin
                m.beats++;
            end
        end
    endtask

    vec_t    vecs[10];
    mstate_t m4, m3;
    int      sent[4];
    int      idx0, idx1, idx3, nb, p, pkn, s;
    logic [63:0] e4, e3;

    initial begin
        vecs[0] = mkv(1, 4'hF, 4'h0, 32'h0,         1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
        vecs[1] = mkv(0, 4'h4, 4'h0, 32'h0048_0000, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
        vecs[2] = mkv(0, 4'h4, 4'h0, 32'h0048_0000, 1, 4'h4, 4'h4, 1, 0, 0, 8'h48);
        vecs[3] = mkv(0, 4'h4, 4'h4, 32'h0069_0000, 1, 4'h4, 4'h4, 1, 1, 0, 8'h69);
        vecs[4] = mkv(0, 4'h0, 4'h0, 32'h0,         1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
        vecs[5] = mkv(0, 4'h9, 4'h9, 32'hB300_00A0, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
        vecs[6] = mkv(0, 4'h9, 4'h9, 32'hB300_00A0, 1, 4'h8, 4'h8, 1, 1, 0, 8'hB3);
        vecs[7] = mkv(0, 4'h9, 4'h9, 32'hB300_00A0, 1, 4'h0, 4'h0, 0, 0, 0, 8'h00);
        vecs[8] = mkv(0, 4'h9, 4'h9, 32'hB300_00A0, 1, 4'h1, 4'h1, 1, 1, 0, 8'hA0);
        vecs[9] = mkv(0, 4'h0, 4'h0, 32'h0,         1, 4'h0, 4'h0, 0, 0, 0, 8'h00);

        rst = 1'b1;
        tv4 = '0; tl4 = '0; td4 = '0; tr4 = 1'b0;
        tv3 = '0; tl3 = '0; td3 = '0; tr3 = 1'b0;
        repeat (3) @(negedge clk);

        // Vector table on the 4-source instance.
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst; tv4 = vecs[i].tv; tl4 = vecs[i].tl; td4 = vecs[i].td; tr4 = vecs[i].tr;
            #1;
            check($sformatf("vec[%0d]", i), act4(),
                  pk(vecs[i].eg, vecs[i].etr, vecs[i].ev, vecs[i].el, vecs[i].et, vecs[i].ed));
            @(negedge clk);
        end

        // All four sources always valid with 3-byte packets: rotation 0,1,2,3,0 with one dead cycle each.
        do_reset();
        for (int k = 0; k < 4; k++) sent[k] = 0;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 4; k++) begin
                td4[k*8 +: 8] = 8'(k*16 + sent[k]);
                tl4[k]        = (sent[k] % 3 == 2);
            end
            tv4 = 4'hF; tr4 = 1'b1;
            #1;
            p = c % 4; pkn = c / 4; s = pkn % 4;
            if (p == 0) check($sformatf("fair[%0d]", c), act4(), pk(0, 0, 0, 0, 0, 0));
            else check($sformatf("fair[%0d]", c), act4(),
                       pk(4'(1 << s), 4'(1 << s), 1, p == 3, 0, 8'(s*16 + (pkn/4)*3 + p - 1)));
            for (int k = 0; k < 4; k++) if (otr4[k]) sent[k]++;
            @(negedge clk);
        end

        // Sink stalls during a 4-byte packet from source 1.
        do_reset();
        idx1 = 0; nb = 0;
        for (int c = 0; c < 8; c++) begin
            case (c)
                2, 3:    tr4 = 1'b0;
                default: tr4 = 1'b1;
            endcase
            tv4 = {2'b00, idx1 < 4, 1'b0};
            td4 = {16'h0, 8'(8'h10 + idx1), 8'h00};
            tl4 = {2'b00, idx1 == 3, 1'b0};
            #1;
            if (c == 0 || nb == 4) check($sformatf("stall[%0d]", c), act4(), pk(0, 0, 0, 0, 0, 0));
            else check($sformatf("stall[%0d]", c), act4(),
                       pk(4'h2, tr4 ? 4'h2 : 4'h0, 1, nb == 3, 0, 8'(8'h10 + nb)));
            if (otr4[1] && tv4[1]) idx1++;
            if (c > 0 && nb < 4 && tr4) nb++;
            @(negedge clk);
        end

        // Watchdog: source 0 streams 10 bytes without tlast, source 1 has a pending 2-byte packet.
        begin
            logic [3:0] tg[17]  = '{0,1,1,1,1,0,2,2,0,1,1,1,1,0,1,1,1};
            logic       tvl[17] = '{0,1,1,1,1,0,1,1,0,1,1,1,1,0,1,1,0};
            logic [7:0] tdd[17] = '{0,0,1,2,3,0,8'h80,8'h81,0,4,5,6,7,0,8,9,0};
            logic       tls[17] = '{0,0,0,0,1,0,0,1,0,0,0,0,1,0,0,0,0};
            logic       trn[17] = '{0,0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,0};
            do_reset();
            idx0 = 0; idx1 = 0;
            for (int c = 0; c < 17; c++) begin
                tr4 = 1'b1;
                tv4 = {2'b00, idx1 < 2, idx0 < 10};
                td4 = {16'h0, 8'(8'h80 + idx1), 8'(idx0)};
                tl4 = {2'b00, idx1 == 1, 1'b0};
                #1;
                check($sformatf("trunc[%0d]", c), act4(), pk(tg[c], tg[c], tvl[c], tls[c], trn[c], tdd[c]));
                if (otr4[0] && tv4[0]) idx0++;
                if (otr4[1] && tv4[1]) idx1++;
                @(negedge clk);
            end
        end

        // Reset after two beats of a 5-byte packet from source 3, then 0 and 3 contend.
        do_reset();
        idx3 = 0;
        for (int c = 0; c < 4; c++) begin
            rst = (c == 3);
            tr4 = 1'b1; tv4 = 4'h8; tl4 = {idx3 == 4, 3'b000};
            td4 = {8'(8'h30 + idx3), 24'h0};
            #1;
            if (c == 0) check("rstpkt[0]", act4(), pk(0, 0, 0, 0, 0, 0));
            else check($sformatf("rstpkt[%0d]", c), act4(), pk(4'h8, 4'h8, 1, 0, 0, 8'(8'h30 + c - 1)));
            if (otr4[3]) idx3++;
            @(negedge clk);
        end
        rst = 1'b0;
        tv4 = 4'h9; tl4 = 4'h1; td4 = {8'(8'h30 + idx3), 16'h0, 8'h55};
        #1;
        check("rstpkt_after", act4(), pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        check("rstpkt_ptr0", act4(), pk(4'h1, 4'h1, 1, 1, 0, 8'h55));
        @(negedge clk);

        // 3-source instance: sources 1 and 2 requesting, 2-byte packets, grants 1,2,1,2.
        do_reset();
        for (int k = 0; k < 3; k++) sent[k] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int k = 0; k < 3; k++) begin
                td3[k*8 +: 8] = 8'(k*16 + sent[k]);
                tl3[k]        = (sent[k] % 2 == 1);
            end
            tv3 = 3'b110; tr3 = 1'b1;
            #1;
            p = c % 3; pkn = c / 3; s = (pkn % 2 == 0) ? 1 : 2;
            if (p == 0) check($sformatf("rr3[%0d]", c), act3(), pk(0, 0, 0, 0, 0, 0));
            else check($sformatf("rr3[%0d]", c), act3(),
                       pk(4'(1 << s), 4'(1 << s), 1, p == 2, 0, 8'(s*16 + (pkn/2)*2 + p - 1)));
            for (int k = 0; k < 3; k++) if (otr3[k]) sent[k]++;
            @(negedge clk);
        end

        // Randomized run against the reference model on both instances.
        do_reset();
        m4 = '{owner: -1, beats: 0, ptr: 0};
        m3 = '{owner: -1, beats: 0, ptr: 0};
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 4; k++) begin
                tv4[k] = ($urandom_range(0, 9) < 7);
                tl4[k] = ($urandom_range(0, 9) < 2);
            end
            for (int k = 0; k < 3; k++) begin
                tv3[k] = ($urandom_range(0, 9) < 6);
                tl3[k] = ($urandom_range(0, 9) < 3);
            end
            td4 = $urandom;
            td3 = 24'($urandom);
            tr4 = ($urandom_range(0, 3) != 0);
            tr3 = ($urandom_range(0, 3) != 0);
            #1;
            model_cycle(4, 4, rst, tv4, tl4, td4, tr4, m4, e4);
            model_cycle(3, 0, rst, {1'b0, tv3}, {1'b0, tl3}, {8'h0, td3}, tr3, m3, e3);
            check("rand4", act4(), e4);
            check("rand3", act3(), e3);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/corescore_axis_rr_arbiter.md
Name: corescore_axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-stream byte sink, the UART emitter, between NUM_SOURCES core stream sources.
- Sits between the per-core stream outputs inside the core-array wrapper and the emitter input.
- Grants one source per packet; the grant is held until that source's tlast beat.
- An optional watchdog truncates runaway packets so one hung core cannot starve the others.

Parameters:
- NUM_SOURCES, 4, number of requesting stream sources (>=2).
- DATA_WIDTH, 8, tdata width per source.
- MAX_BEATS, 256, maximum beats per packet before forced release. 0 disables the watchdog.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_tdata  input  NUM_SOURCES*DATA_WIDTH  source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_tlast  input  NUM_SOURCES  per-source end-of-packet.
- i_tvalid  input  NUM_SOURCES  per-source valid.
- o_tready  output  NUM_SOURCES  per-source ready.
- o_tdata  output  DATA_WIDTH  data to sink.
- o_tlast  output  1  end-of-packet to sink.
- o_tvalid  output  1  valid to sink.
- i_tready  input  1  sink ready.
- o_grant  output  NUM_SOURCES  one-hot current grant; all-zero when idle.
- o_trunc  output  1  one-cycle pulse when the watchdog truncates a packet.

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, round-robin pointer ptr=0, beat counter=0.
  - o_tvalid=0, o_tready=0, o_grant=0, o_trunc=0.
- State IDLE:
  - All o_tready=0 and o_tvalid=0. No transfers occur.
  - If any i_tvalid is set, select the first valid source scanning ptr, ptr+1, ... NUM_SOURCES-1, 0, ... ptr-1.
  - Register the selection into grant and move to LOCKED on the next edge.
  - With no valid source, stay in IDLE.
- State LOCKED, granted index g:
  - o_tvalid=i_tvalid[g]; o_tdata=source g data; o_tready[g]=i_tready; all other o_tready=0. These paths are combinational.
  - o_tlast = i_tlast[g] OR (watchdog enabled AND beat counter == MAX_BEATS-1).
  - A beat is o_tvalid & i_tready. Each beat increments the beat counter.
- Release:
  - On a beat with o_tlast=1: return to IDLE, clear grant and the beat counter, and set ptr = (g+1) mod NUM_SOURCES.
  - If the release was forced (i_tlast[g]=0), pulse o_trunc for exactly that cycle.
  - Source g's remaining bytes are handled as a new packet later and compete normally.
- Latency: one idle cycle between consecutive packets (grant overhead). Within a packet, throughput is one beat per cycle when valid and ready are both high.
- Stalls:
  - i_tready low holds the current beat; the counter does not advance.
  - Source valid low inside a packet keeps the lock and emits no beat.
- Request changes in IDLE: a source deasserting tvalid before grant is not a protocol concern. Selection uses the i_tvalid value in the cycle the grant registers.
- Simultaneous requests: strict rotation. A source just served has lowest priority next.
- Fairness: with all sources continuously requesting, the grant order is 0,1,2,...,N-1,0,...
- Single-beat packets (tlast on the first beat) are legal: one beat, then release.
- Reset mid-packet: the lock is dropped at the reset edge. In the next cycle all outputs take their reset values and ptr=0. The partial packet is not completed.
- Width rules:
  - Beat counter width = clog2(MAX_BEATS+1). The counter never wraps because release occurs at MAX_BEATS.
  - ptr width = clog2(NUM_SOURCES). Wrap from NUM_SOURCES-1 to 0 is explicit, which covers non-power-of-2 counts.

Test Plan:
- Single source 2 sends bytes 0x48,0x69 with tlast on 0x69, sink always ready:
  - one IDLE cycle, then o_grant=0b0100 and o_tdata sequence 0x48,0x69 with o_tlast on the second byte.
  - o_grant=0 the following cycle.
- All 4 sources continuously valid with 3-byte packets:
  - grants rotate 0,1,2,3,0.
  - exactly one dead cycle between packets; no byte interleaving between sources.
- Sink i_tready toggles 1,0,0,1 during a packet from source 1:
  - o_tdata held stable while stalled; o_tready[1] mirrors i_tready; no beats duplicated or lost.
- MAX_BEATS=4, source 0 streams 10 bytes without tlast:
  - o_tlast forced on beat 4 with an o_trunc pulse.
  - source 1, already pending, is granted next.
  - source 0's remaining bytes are handled as a later packet.
- i_rst asserted after 2 beats of a 5-byte packet from source 3:
  - the cycle after the reset edge shows o_tvalid=0, o_tready=0, o_grant=0.
  - after release, simultaneous requests from 0 and 3 grant source 0 first (ptr=0).
- NUM_SOURCES=3, sources 1 and 2 both requesting:
  - grant order 1,2,1,2; after a grant to 2, ptr wraps to 0 and source 1 wins over source 2.
